word_byte_reader: RTL and testbench

Unpacks 16-bit words into a stream of 8-bit bytes, high half first, under per-half select control. It is the read-side counterpart of the split high/low load register: the register assembles a word from independently loaded halves, and this block reads a word back out one half at a time. It sits between a word-wide source (memory data register or datapath) and a byte-wide sink (UART TX, display driver, byte bus), with valid/ready handshakes on both sides.

---
 rtl/word_byte_reader_if.sv | 29 ++
 rtl/word_byte_reader.sv | 81 ++++++++
 tb/tb_word_byte_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/word_byte_reader_if.sv
// word_byte_reader_if: word-in / byte-out handshake bundle for word_byte_reader.
//   Word side: in_valid, in_ready, in_data[WIDTH], in_selh, in_sell.
//   Byte side: out_valid, out_ready, out_data[WIDTH/2], out_hi, out_last.
//   slave  : the unpacker (consumes words, produces bytes)
//   master : the environment (word source plus byte sink)
interface word_byte_reader_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_selh;
    logic                 in_sell;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH/2-1:0]   out_data;
    logic                 out_hi;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, in_selh, in_sell, out_ready,
        output in_ready, out_valid, out_data, out_hi, out_last
    );

    modport master (
        output in_valid, in_data, in_selh, in_sell, out_ready,
        input  in_ready, out_valid, out_data, out_hi, out_last
    );
endinterface

// File: rtl/word_byte_reader.sv
// word_byte_reader: unpacks WIDTH-bit words into WIDTH/2-bit bytes, high half
// first, emitting only the halves selected when the word was accepted.
//   clk        : rising-edge clock
//   clear      : asynchronous active-high reset
//   bus        : word_byte_reader_if.slave (word handshake in, byte handshake out)
//   byte_count : bytes transferred since clear, wraps at 16 bits
module word_byte_reader #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      clear,
    word_byte_reader_if.slave         bus,
    output logic [15:0]               byte_count
);
    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] held_data;
    logic             held_sell;
    logic             accept, xfer, finish;
    state_t           entry_state;

    // Byte-side outputs depend only on state and the holding register.
    always_comb begin
        bus.out_valid = (state != IDLE);
        bus.out_hi    = (state == HI);
        bus.out_last  = (state == LO) || (state == HI && !held_sell);
        bus.out_data  = (state == LO) ? held_data[HALF-1:0] : held_data[WIDTH-1:HALF];
    end

    assign xfer   = bus.out_valid && bus.out_ready;
    assign finish = xfer && bus.out_last;
    // Ready when empty, or when the last byte leaves this cycle so a new
    // word can be taken back-to-back.
    assign bus.in_ready = (state == IDLE) || finish;
    assign accept = bus.in_valid && bus.in_ready;

    // First state for a freshly accepted word; no selects means it is
    // consumed without emitting anything.
    always_comb begin
        entry_state = IDLE;
        if (bus.in_selh)      entry_state = HI;
        else if (bus.in_sell) entry_state = LO;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = entry_state;
            HI: begin
                if (xfer) begin
                    if (held_sell)   state_next = LO;
                    else if (accept) state_next = entry_state;
                    else             state_next = IDLE;
                end
            end
            LO: begin
                if (xfer) state_next = accept ? entry_state : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            held_data  <= '0;
            held_sell  <= 1'b0;
            byte_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                held_data <= bus.in_data;
                held_sell <= bus.in_sell;
            end
            if (xfer) byte_count <= byte_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_word_byte_reader.sv
module tb_word_byte_reader;
    typedef struct {
        logic [7:0] d;
        logic       hi;
        logic       last;
    } byte_t;

    logic        clk = 1'b0;
    logic        clear;
    logic [15:0] byte_count;
    int          checks = 0;
    int          failures = 0;
    byte_t       q[$];
    logic [15:0] mcount = 16'd0;

    word_byte_reader_if #(.WIDTH(16)) bus ();

    word_byte_reader #(.WIDTH(16)) dut (
        .clk        (clk),
        .clear      (clear),
        .bus        (bus.slave),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the byte queue,
    // then advance the queue on the rising edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic sh,
                         input logic sl, input logic ordy);
        logic exp_ready, acc, xf;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_selh   = sh;
        bus.in_sell   = sl;
        bus.out_ready = ordy;
        #1;
        exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("out_valid", {15'd0, bus.out_valid}, {15'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_data", {8'd0, bus.out_data}, {8'd0, q[0].d});
            chk("out_hi",   {15'd0, bus.out_hi},   {15'd0, q[0].hi});
            chk("out_last", {15'd0, bus.out_last}, {15'd0, q[0].last});
        end
        chk("in_ready", {15'd0, bus.in_ready}, {15'd0, exp_ready});
        chk("byte_count", byte_count, mcount);
        acc = v && exp_ready;
        xf  = (q.size() != 0) && ordy;
        @(posedge clk);
        if (xf) begin
            void'(q.pop_front());
            mcount = mcount + 16'd1;
        end
        if (acc) begin
            if (sh) q.push_back('{d[15:8], 1'b1, !sl});
            if (sl) q.push_back('{d[7:0], 1'b0, 1'b1});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        clear         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_selh   = 1'b0;
        bus.in_sell   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_out_data",  {8'd0, bus.out_data},   16'd0);
        chk("rst_out_hi",    {15'd0, bus.out_hi},    16'd0);
        chk("rst_out_last",  {15'd0, bus.out_last},  16'd0);
        chk("rst_in_ready",  {15'd0, bus.in_ready},  16'd1);
        chk("rst_count",     byte_count,             16'd0);
        @(negedge clk);
        clear = 1'b0;
        idle(2);

        // Clear mid-HI: the pending low byte must vanish.
        cycle(1'b1, 16'hA55A, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'hA55A, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clr_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("clr_count",     byte_count,             16'd0);
        chk("clr_in_ready",  {15'd0, bus.in_ready},  16'd1);
        q.delete();
        mcount = 16'd0;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'hA55A, 1'b0, 1'b0, 1'b1);

        // Both halves.
        cycle(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        idle(3);
        chk("both_count", byte_count, 16'd2);

        // Single halves and the empty word.
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        idle(2);
        cycle(1'b1, 16'hCAFE, 1'b0, 1'b1, 1'b1);
        idle(2);
        cycle(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk("single_count", byte_count, 16'd4);

        // Backpressure: offered word must not be taken while stalled.
        cycle(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h9999, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Back-to-back words.
        cycle(1'b1, 16'h0102, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 16'h0304, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 16'h0304, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        idle(4);

        // Wrap: one-byte words streamed one per cycle.
        @(negedge clk);
        clear = 1'b1;
        q.delete();
        mcount = 16'd0;
        @(negedge clk);
        clear = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h5500;
        bus.in_selh   = 1'b1;
        bus.in_sell   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        // 65536 accepts, first byte transferred one cycle after the first.
        chk("wrap_count", byte_count, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap_zero", byte_count, 16'd0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_one", byte_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
